fifo_umbral: RTL

Single transmit-path FIFO with programmable almost-full/almost-empty thresholds. It is the storage element driven by the threshold outputs of the transmit-layer control state machine. Five instances (main FIFO, two VC FIFOs, two D FIFOs) produce the FIFO_empties[4:0] and FIFO_errors[4:0] vectors that the control state machine consumes. Each instance provides registered-read data plus status flags for downstream arbitration.

---
 rtl/fifo_umbral.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_umbral.sv
// Transmit-path FIFO with registered read data, sticky error flag and
// programmable almost-full / almost-empty thresholds.
module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3,
  parameter int U_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [U_W-1:0]    umbral_alto,
  input  logic [U_W-1:0]    umbral_bajo,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam int TW    = (U_W > CW) ? U_W : CW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              error_r;

  logic              push_ok_s;
  logic              pop_ok_s;
  logic              full_s;
  logic              empty_s;
  logic              error_set_s;
  logic              almost_full_s;
  logic              almost_empty_s;
  logic [TW-1:0]     count_ext_s;
  logic [TW-1:0]     alto_ext_s;
  logic [TW-1:0]     bajo_ext_s;

  // Acceptance, error detection and threshold comparison.
  always_comb begin
    empty_s        = (count_r == {CW{1'b0}});
    full_s         = (count_r == DEPTH_C);
    // A push into a full FIFO is only rescued by a pop that is itself accepted.
    pop_ok_s       = pop && !empty_s;
    push_ok_s      = push && (!full_s || pop_ok_s);
    error_set_s    = (push && !push_ok_s) || (pop && empty_s);
    count_ext_s    = TW'(count_r);
    alto_ext_s     = TW'(umbral_alto);
    bajo_ext_s     = TW'(umbral_bajo);
    almost_full_s  = (alto_ext_s != {TW{1'b0}}) && (count_ext_s >= alto_ext_s);
    almost_empty_s = (count_ext_s <= bajo_ext_s);
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy, read register and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {CW{1'b0}};
      data_r   <= {DATA_W{1'b0}};
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
        data_r   <= mem_r[rd_ptr_r];
        valid_r  <= 1'b1;
      end else begin
        valid_r  <= 1'b0;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (error_set_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign data_out     = data_r;
  assign valid_out    = valid_r;
  assign fifo_error   = error_r;
  assign count        = count_r;
  assign fifo_empty   = empty_s;
  assign fifo_full    = full_s;
  assign almost_full  = almost_full_s;
  assign almost_empty = almost_empty_s;

endmodule
